// File: rtl/qa_drv_mem_rd_buf_pkg.sv
// rtl/qa_drv_mem_rd_buf_pkg.sv - shared types and constants for the driver-memory read buffer
//   Exports: CCI line/address types, default response-buffer depth, credit and stat counter types,
//   and a saturating increment used by the optional stat counters.
package qa_driver_memory_types;

    localparam int CCI_CLDATA_WIDTH       = 512;
    localparam int CCI_MPF_CL_VADDR_WIDTH = 42;

    typedef logic [CCI_CLDATA_WIDTH-1:0]       t_cci_cldata;
    typedef logic [CCI_MPF_CL_VADDR_WIDTH-1:0] t_cci_mpf_cl_vaddr;

    localparam int RSP_BUF_DEPTH_DEFAULT = 64;

    // One extra bit so "all slots free" (== depth) is representable.
    typedef logic [$clog2(RSP_BUF_DEPTH_DEFAULT):0] t_rd_buf_credits;
    typedef logic [31:0]                             t_rd_buf_stat;

    localparam t_rd_buf_stat STAT_MAX = '1;

    function automatic t_rd_buf_stat sat_inc(input t_rd_buf_stat v);
        return (v == STAT_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/qa_drv_mem_rd_buf_if.sv
// rtl/qa_drv_mem_rd_buf_if.sv - client-side and driver-side read bundles for qa_drv_mem_rd_buf
//   qa_drv_mem_rd_buf_if     : client request (addr/cached/check_order/valid/ready) and response
//                              (data/valid/ready); master = client, slave = read buffer.
//   qa_drv_mem_rd_buf_mem_if : driver read port (req fields/enable/rdy, rsp data/rdy);
//                              master = read buffer, slave = driver.
interface qa_drv_mem_rd_buf_if;
    import qa_driver_memory_types::*;

    t_cci_mpf_cl_vaddr req_addr;
    logic              req_cached;
    logic              req_check_order;
    logic              req_valid;
    logic              req_ready;
    t_cci_cldata       rsp_data;
    logic              rsp_valid;
    logic              rsp_ready;

    modport master (
        output req_addr, req_cached, req_check_order, req_valid, rsp_ready,
        input  req_ready, rsp_data, rsp_valid
    );

    modport slave (
        input  req_addr, req_cached, req_check_order, req_valid, rsp_ready,
        output req_ready, rsp_data, rsp_valid
    );
endinterface

interface qa_drv_mem_rd_buf_mem_if;
    import qa_driver_memory_types::*;

    t_cci_mpf_cl_vaddr mem_read_req_addr;
    logic              mem_read_req_cached;
    logic              mem_read_req_check_order;
    logic              mem_read_req_enable;
    logic              mem_read_req_rdy;
    t_cci_cldata       mem_read_rsp_data;
    logic              mem_read_rsp_rdy;

    modport master (
        output mem_read_req_addr, mem_read_req_cached, mem_read_req_check_order, mem_read_req_enable,
        input  mem_read_req_rdy, mem_read_rsp_data, mem_read_rsp_rdy
    );

    modport slave (
        input  mem_read_req_addr, mem_read_req_cached, mem_read_req_check_order, mem_read_req_enable,
        output mem_read_req_rdy, mem_read_rsp_data, mem_read_rsp_rdy
    );
endinterface

// File: rtl/qa_drv_mem_rd_buf_rsp_fifo.sv
// rtl/qa_drv_mem_rd_buf_rsp_fifo.sv - response FIFO (qa_drv_mem_rsp_fifo), DEPTH x t_cci_cldata
//   Ports: clk, reset_n (sync, active-low), push_i/push_data_i, pop_i,
//          head_data_o (flop-held head entry), full_o, empty_o, count_o.
module qa_drv_mem_rsp_fifo
    import qa_driver_memory_types::*;
#(
    parameter int DEPTH = RSP_BUF_DEPTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 push_i,
    input  t_cci_cldata          push_data_i,
    input  logic                 pop_i,
    output t_cci_cldata          head_data_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    t_cci_cldata   mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;

    // Pointers carry one extra MSB: equal index with differing MSB means full.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_i};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_i};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // At full, a same-cycle push overwrites the head slot only after this cycle's pop has read it.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    assign head_data_o = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o     = (wr_ptr_q == rd_ptr_q);
    assign full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o     = wr_ptr_q - rd_ptr_q;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(pop_i && empty_o)) else $fatal(1, "rsp fifo pop while empty");
        end
    end
endmodule

// File: rtl/qa_drv_mem_rd_buf.sv
// rtl/qa_drv_mem_rd_buf.sv - credit-based read request/response buffer in front of qa_drv_memory
//   Ports: clk, reset_n (sync, active-low); client (qa_drv_mem_rd_buf_if.slave): request and
//   in-order response handshakes; mem (qa_drv_mem_rd_buf_mem_if.master): driver read port;
//   idle; stat_reads, stat_credit_stalls (live only with QA_DRV_MEM_RD_BUF_STATS_EN, else 0).
module qa_drv_mem_rd_buf
    import qa_driver_memory_types::*;
#(
    parameter int RSP_BUF_DEPTH = RSP_BUF_DEPTH_DEFAULT
) (
    input  logic                           clk,
    input  logic                           reset_n,
    qa_drv_mem_rd_buf_if.slave             client,
    qa_drv_mem_rd_buf_mem_if.master        mem,
    output logic                           idle,
    output t_rd_buf_stat                   stat_reads,
    output t_rd_buf_stat                   stat_credit_stalls
);
    localparam int              CW           = $clog2(RSP_BUF_DEPTH) + 1;
    localparam logic [CW-1:0]   CREDITS_FULL = CW'(RSP_BUF_DEPTH);
    localparam logic [CW-1:0]   CREDIT_ONE   = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] credits_q, credits_d;
    logic          credits_zero;
    logic          issue;
    logic          pop;
    logic          push;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    assign credits_zero     = (credits_q == '0);
    assign client.req_ready = reset_n && mem.mem_read_req_rdy && !credits_zero;
    assign issue            = client.req_valid && client.req_ready;
    assign pop              = client.rsp_valid && client.rsp_ready;
    // Driver responses cannot be back-pressured; anything arriving during reset is discarded.
    assign push             = reset_n && mem.mem_read_rsp_rdy;

    assign mem.mem_read_req_addr        = client.req_addr;
    assign mem.mem_read_req_cached      = client.req_cached;
    assign mem.mem_read_req_check_order = client.req_check_order;
    assign mem.mem_read_req_enable      = issue;

    // Credits track free FIFO slots: reserved at issue, returned only when the client dequeues.
    always_comb begin
        credits_d = credits_q;
        case ({issue, pop})
            2'b10:   credits_d = credits_q - CREDIT_ONE;
            2'b01:   credits_d = credits_q + CREDIT_ONE;
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            credits_q <= CREDITS_FULL;
        end else begin
            credits_q <= credits_d;
        end
    end

    assign idle = (credits_q == CREDITS_FULL);

    qa_drv_mem_rsp_fifo #(
        .DEPTH (RSP_BUF_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push),
        .push_data_i (mem.mem_read_rsp_data),
        .pop_i       (pop),
        .head_data_o (client.rsp_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign client.rsp_valid = !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (credits_q <= CREDITS_FULL) else $fatal(1, "read credits exceed buffer depth");
            assert (!(push && fifo_full && !pop)) else $fatal(1, "response pushed into full fifo");
            assert (int'(credits_q) + int'(fifo_count) <= RSP_BUF_DEPTH)
                else $fatal(1, "credits and buffered responses exceed depth");
        end
    end

`ifdef QA_DRV_MEM_RD_BUF_STATS_EN
    t_rd_buf_stat reads_q;
    t_rd_buf_stat stalls_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            reads_q  <= '0;
            stalls_q <= '0;
        end else begin
            if (issue) begin
                reads_q <= sat_inc(reads_q);
            end
            // Only stalls caused by credits count; driver back-pressure is not ours.
            if (client.req_valid && mem.mem_read_req_rdy && credits_zero) begin
                stalls_q <= sat_inc(stalls_q);
            end
        end
    end

    assign stat_reads         = reads_q;
    assign stat_credit_stalls = stalls_q;
`else
    assign stat_reads         = '0;
    assign stat_credit_stalls = '0;
`endif
endmodule

// File: tb/tb_qa_drv_mem_rd_buf.sv
// tb/tb_qa_drv_mem_rd_buf.sv - directed self-checking bench for qa_drv_mem_rd_buf (DEPTH=4)
module tb_qa_drv_mem_rd_buf;
    import qa_driver_memory_types::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    qa_drv_mem_rd_buf_if     client_if ();
    qa_drv_mem_rd_buf_mem_if mem_if ();

    logic         idle;
    t_rd_buf_stat stat_reads;
    t_rd_buf_stat stat_credit_stalls;

    qa_drv_mem_rd_buf #(
        .RSP_BUF_DEPTH (DEPTH)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .client             (client_if.slave),
        .mem                (mem_if.master),
        .idle               (idle),
        .stat_reads         (stat_reads),
        .stat_credit_stalls (stat_credit_stalls)
    );

    int n_cmp = 0;
    int n_bad = 0;

    t_cci_mpf_cl_vaddr exp_q[$];
    t_cci_mpf_cl_vaddr pend_q[$];
    t_cci_mpf_cl_vaddr na = 42'h100;

    function automatic t_cci_cldata mkdata(input t_cci_mpf_cl_vaddr a);
        return {8{22'h3A5C1, a}};
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input t_cci_cldata obs, input t_cci_cldata exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input t_cci_mpf_cl_vaddr a);
        client_if.req_valid       = 1'b1;
        client_if.req_addr        = a;
        client_if.req_cached      = a[0];
        client_if.req_check_order = a[1];
    endtask

    task automatic issue_next();
        drive_req(na);
        #1;
        chk1("issue_req_ready", client_if.req_ready, 1'b1);
        chk1("issue_enable", mem_if.mem_read_req_enable, 1'b1);
        chkw("issue_addr", 512'(mem_if.mem_read_req_addr), 512'(na));
        chkw("issue_flags", 512'({mem_if.mem_read_req_cached, mem_if.mem_read_req_check_order}),
             512'({na[0], na[1]}));
        exp_q.push_back(na);
        pend_q.push_back(na);
        na = na + 42'h41;
        @(negedge clk);
        client_if.req_valid = 1'b0;
    endtask

    task automatic respond();
        mem_if.mem_read_rsp_rdy  = 1'b1;
        mem_if.mem_read_rsp_data = mkdata(pend_q.pop_front());
        @(negedge clk);
        mem_if.mem_read_rsp_rdy  = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        client_if.rsp_ready = 1'b1;
        #1;
        chk1({tag, "_rsp_valid"}, client_if.rsp_valid, 1'b1);
        chkw({tag, "_rsp_data"}, client_if.rsp_data, mkdata(exp_q.pop_front()));
        @(negedge clk);
        client_if.rsp_ready = 1'b0;
    endtask

    initial begin
        client_if.req_valid       = 1'b0;
        client_if.req_addr        = '0;
        client_if.req_cached      = 1'b0;
        client_if.req_check_order = 1'b0;
        client_if.rsp_ready       = 1'b0;
        mem_if.mem_read_req_rdy   = 1'b1;
        mem_if.mem_read_rsp_rdy   = 1'b0;
        mem_if.mem_read_rsp_data  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk1("rst_req_ready", client_if.req_ready, 1'b0);
        chk1("rst_rsp_valid", client_if.rsp_valid, 1'b0);
        chk1("rst_idle", idle, 1'b1);
        chkw("rst_stat_reads", 512'(stat_reads), 512'(0));
        chkw("rst_stat_stalls", 512'(stat_credit_stalls), 512'(0));
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk1("post_rst_req_ready", client_if.req_ready, 1'b1);
        @(negedge clk);

        // Single read: response pulse in cycle N gives rsp_valid in N+1
        issue_next();
        #1;
        chk1("t1_busy", idle, 1'b0);
        mem_if.mem_read_rsp_rdy  = 1'b1;
        mem_if.mem_read_rsp_data = mkdata(pend_q.pop_front());
        #1;
        chk1("t1_rsp_not_yet", client_if.rsp_valid, 1'b0);
        @(negedge clk);
        mem_if.mem_read_rsp_rdy = 1'b0;
        pop_check("t1");
        #1;
        chk1("t1_rsp_drained", client_if.rsp_valid, 1'b0);
        chk1("t1_idle", idle, 1'b1);
        @(negedge clk);

        // Fill all credits; 5th request held until a pop, then issues next cycle
        for (int i = 0; i < DEPTH; i++) issue_next();
        drive_req(na);
        #1;
        chk1("t2_full_req_ready", client_if.req_ready, 1'b0);
        chk1("t2_full_enable", mem_if.mem_read_req_enable, 1'b0);
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) respond();
        #1;
        chk1("t2_held_after_rsp", client_if.req_ready, 1'b0);
        pop_check("t2_pop");
        #1;
        chk1("t2_released_ready", client_if.req_ready, 1'b1);
        chk1("t2_released_enable", mem_if.mem_read_req_enable, 1'b1);
        exp_q.push_back(na);
        pend_q.push_back(na);
        na = na + 42'h41;
        @(negedge clk);
        client_if.req_valid = 1'b0;
        respond();
        for (int i = 0; i < DEPTH; i++) pop_check("t2_drain");
        #1;
        chk1("t2_idle", idle, 1'b1);
        @(negedge clk);

        // Driver not ready with credits available
        mem_if.mem_read_req_rdy = 1'b0;
        drive_req(na);
        #1;
        chk1("t3_req_ready", client_if.req_ready, 1'b0);
        chk1("t3_enable", mem_if.mem_read_req_enable, 1'b0);
        @(negedge clk);
        client_if.req_valid     = 1'b0;
        mem_if.mem_read_req_rdy = 1'b1;
        #1;
        chk1("t3_idle", idle, 1'b1);
        chk1("t3_ready_again", client_if.req_ready, 1'b1);
        @(negedge clk);

        // credits==1, issue+pop+response every cycle across pointer wrap
        for (int i = 0; i < DEPTH - 1; i++) issue_next();
        respond();
        respond();
        for (int i = 0; i < 20; i++) begin
            drive_req(na);
            client_if.rsp_ready      = 1'b1;
            mem_if.mem_read_rsp_rdy  = 1'b1;
            mem_if.mem_read_rsp_data = mkdata(pend_q.pop_front());
            #1;
            chk1("t4_req_ready", client_if.req_ready, 1'b1);
            chk1("t4_rsp_valid", client_if.rsp_valid, 1'b1);
            chkw("t4_rsp_data", client_if.rsp_data, mkdata(exp_q.pop_front()));
            exp_q.push_back(na);
            pend_q.push_back(na);
            na = na + 42'h41;
            @(negedge clk);
        end
        client_if.req_valid     = 1'b0;
        client_if.rsp_ready     = 1'b0;
        mem_if.mem_read_rsp_rdy = 1'b0;
        respond();
        for (int i = 0; i < DEPTH - 1; i++) pop_check("t4_drain");
        #1;
        chk1("t4_idle", idle, 1'b1);
        @(negedge clk);

        // Reset mid-stream with 3 outstanding; a response during reset is dropped
        for (int i = 0; i < 3; i++) issue_next();
        respond();
        #1;
        chk1("t5_pre_rsp_valid", client_if.rsp_valid, 1'b1);
        reset_n                  = 1'b0;
        mem_if.mem_read_rsp_rdy  = 1'b1;
        mem_if.mem_read_rsp_data = mkdata(pend_q.pop_front());
        drive_req(na);
        #1;
        chk1("t5_rst_req_ready", client_if.req_ready, 1'b0);
        chk1("t5_rst_enable", mem_if.mem_read_req_enable, 1'b0);
        @(negedge clk);
        reset_n                 = 1'b1;
        client_if.req_valid     = 1'b0;
        mem_if.mem_read_rsp_rdy = 1'b0;
        exp_q.delete();
        pend_q.delete();
        #1;
        chk1("t5_idle", idle, 1'b1);
        chk1("t5_rsp_valid", client_if.rsp_valid, 1'b0);
        chk1("t5_req_ready", client_if.req_ready, 1'b1);
        chkw("t5_stat_reads", 512'(stat_reads), 512'(0));
        @(negedge clk);

        // Stats: 10 issues, 7 credit-stall cycles, 1 driver-stall cycle that must not count
        for (int i = 0; i < DEPTH; i++) issue_next();
        drive_req(na);
        for (int i = 0; i < 7; i++) begin
            #1;
            chk1("t6_stall_ready", client_if.req_ready, 1'b0);
            @(negedge clk);
        end
        mem_if.mem_read_req_rdy = 1'b0;
        @(negedge clk);
        mem_if.mem_read_req_rdy = 1'b1;
        client_if.req_valid     = 1'b0;
        for (int i = 0; i < DEPTH; i++) respond();
        for (int i = 0; i < DEPTH; i++) pop_check("t6_drain");
        for (int i = 0; i < 6; i++) begin
            issue_next();
            respond();
            pop_check("t6_stream");
        end
        #1;
        chk1("t6_idle", idle, 1'b1);
`ifdef QA_DRV_MEM_RD_BUF_STATS_EN
        chkw("t6_stat_reads", 512'(stat_reads), 512'(10));
        chkw("t6_stat_stalls", 512'(stat_credit_stalls), 512'(7));
`else
        chkw("t6_stat_reads", 512'(stat_reads), 512'(0));
        chkw("t6_stat_stalls", 512'(stat_credit_stalls), 512'(0));
`endif
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
